// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, display limits and helpers
// for the stopwatch time-base and the display driver.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } sw_state_t;

  localparam logic [6:0] CS_MAX   = 7'd99;
  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] HOUR_MAX = 7'd99;

  typedef struct packed {
    logic [6:0] cs;
    logic [6:0] sec;
    logic [6:0] min;
    logic [6:0] hour;
  } sw_time_t;

  function automatic logic [6:0] wrap_inc(
    input logic [6:0] v,
    input logic [6:0] max
  );
    return (v == max) ? 7'd0 : v + 7'd1;
  endfunction

endpackage

// File: rtl/stopwatch_timer_if.sv
// stopwatch_timer_if: raw buttons in, binary time and status out.
// master = time-base core, slave = board/display side.
interface stopwatch_timer_if;

  logic       btn_ss;
  logic       btn_clr;
  logic       btn_lap;
  logic [7:0] centisec;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hour;
  logic       running;
  logic       lap_hold;

  modport master (
    input  btn_ss, btn_clr, btn_lap,
    output centisec, sec, min, hour,
    output running, lap_hold
  );

  modport slave (
    output btn_ss, btn_clr, btn_lap,
    input  centisec, sec, min, hour,
    input  running, lap_hold
  );

endinterface

// File: rtl/stopwatch_timer_debounce.sv
// btn_debounce: 2-FF synchronizer, stability filter and
// one-cycle press pulse for a single raw push-button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // bring the raw pin into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // accept a new level after enough equal samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // pulse only on an accepted press, never on release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: button conditioning, IDLE/RUN/PAUSE control,
// centisecond prescaler, h:m:s.cs cascade and lap freeze.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  stopwatch_timer_if.master sw
);

  localparam int PRE_N = CLK_HZ / 100;
  localparam int PW =
    (PRE_N > 1) ? $clog2(PRE_N) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_N - 1);

  sw_state_t     state;
  logic          running_q;
  logic          lap_hold_q;
  logic [PW-1:0] pre;
  logic [6:0]    cs_q;
  logic [6:0]    sec_q;
  logic [6:0]    min_q;
  logic [6:0]    hour_q;
  sw_time_t      live;
  sw_time_t      lap_q;
  sw_time_t      disp;
  logic          ss_p;
  logic          clr_p;
  logic          lap_p;
  logic          clr_eff;
  logic          lap_eff;
  logic          tick;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_ss (
    .clk  (clk),
    .rst  (rst),
    .btn  (sw.btn_ss),
    .press(ss_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_clr (
    .clk  (clk),
    .rst  (rst),
    .btn  (sw.btn_clr),
    .press(clr_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_lap (
    .clk  (clk),
    .rst  (rst),
    .btn  (sw.btn_lap),
    .press(lap_p)
  );

  assign clr_eff = clr_p && (state != RUN);
  assign lap_eff = lap_p && (state == RUN);
  assign tick    = (state == RUN) && (pre == PRE_LAST);
  assign live    = {cs_q, sec_q, min_q, hour_q};

  // control FSM; clear beats start/stop and lap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
    end else if (clr_eff) begin
      state      <= IDLE;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      if (lap_eff) lap_hold_q <= ~lap_hold_q;
      if (ss_p) begin
        unique case (state)
          IDLE: begin
            state     <= RUN;
            running_q <= 1'b1;
          end
          RUN: begin
            state     <= PAUSE;
            running_q <= 1'b0;
          end
          PAUSE: begin
            state     <= RUN;
            running_q <= 1'b1;
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // prescaler holds in PAUSE to keep the fraction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (clr_eff) begin
      pre <= '0;
    end else if (state == RUN) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

  // cascaded counters, 99:59:59.99 wraps to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q   <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else if (clr_eff) begin
      cs_q   <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else if (tick) begin
      cs_q <= wrap_inc(cs_q, CS_MAX);
      if (cs_q == CS_MAX) begin
        sec_q <= wrap_inc(sec_q, SEC_MAX);
        if (sec_q == SEC_MAX) begin
          min_q <= wrap_inc(min_q, MIN_MAX);
          if (min_q == MIN_MAX) begin
            hour_q <= wrap_inc(hour_q, HOUR_MAX);
          end
        end
      end
    end
  end

  // snapshot live time as the hold is raised
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q <= '0;
    end else if (lap_eff && !lap_hold_q) begin
      lap_q <= live;
    end
  end

  assign disp        = lap_hold_q ? lap_q : live;
  assign sw.centisec = {1'b0, disp.cs};
  assign sw.sec      = {1'b0, disp.sec};
  assign sw.min      = {1'b0, disp.min};
  assign sw.hour     = {1'b0, disp.hour};
  assign sw.running  = running_q;
  assign sw.lap_hold = lap_hold_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer: randomized scenarios checked against an
// elapsed-run-cycles reference model of the stopwatch.
module tb_stopwatch_timer;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  longint ss_at = -1;
  longint clr_at = -1;
  longint lap_at = -1;
  longint pre_at = -1;
  longint pre_val = 0;
  int     m_st = S_IDLE;
  longint m_run = 0;
  longint m_snap = 0;
  bit     m_lap = 1'b0;
  logic   se;
  logic   ce;
  logic   le;
  longint base;

  stopwatch_timer_if sw();

  stopwatch_timer #(
    .CLK_HZ         (1000),
    .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .sw (sw.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign se   = (ss_at == cyc + 1);
  assign ce   = (clr_at == cyc + 1);
  assign le   = (lap_at == cyc + 1);
  assign base = (pre_at == cyc + 1) ? pre_val : m_run;

  // reference: elapsed RUN cycles; centiseconds = cycles / 10
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st   <= S_IDLE;
      m_run  <= 0;
      m_lap  <= 1'b0;
      m_snap <= 0;
    end else begin
      if (m_st == S_RUN) m_run <= base + 1;
      if (ce && m_st != S_RUN) begin
        m_st  <= S_IDLE;
        m_run <= 0;
        m_lap <= 1'b0;
      end else begin
        if (le && m_st == S_RUN) begin
          m_lap <= !m_lap;
          if (!m_lap) m_snap <= base / 10;
        end
        if (se) m_st <= (m_st == S_RUN) ? S_PAUSE : S_RUN;
      end
    end
  end

  function automatic logic [33:0] exp_out();
    longint t;
    t = m_lap ? m_snap : m_run / 10;
    return {8'(t % 100), 8'((t / 100) % 60),
            8'((t / 6000) % 60), 8'((t / 360000) % 100),
            m_st == S_RUN, m_lap};
  endfunction

  function automatic logic [33:0] obs();
    return {sw.centisec, sw.sec, sw.min, sw.hour,
            sw.running, sw.lap_hold};
  endfunction

  // raw press held for hold cycles; a pulse reaches the FSM 8 edges on
  task automatic press(input bit s, input bit c,
                       input bit l, input int hold);
    sw.btn_ss  = s;
    sw.btn_clr = c;
    sw.btn_lap = l;
    if (hold >= 4) begin
      if (s) ss_at = cyc + 8;
      if (c) clr_at = cyc + 8;
      if (l) lap_at = cyc + 8;
    end
    repeat (hold) @(negedge clk);
    sw.btn_ss  = 1'b0;
    sw.btn_clr = 1'b0;
    sw.btn_lap = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_run(input longint r);
    for (int i = 0; i < 20000 && m_run != r; i++)
      @(negedge clk);
    total++;
    if (m_run != r) begin
      bad++;
      $display("FAIL wait_run: got %0d want %0d", m_run, r);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (obs() !== 34'h0) begin
      bad++;
      $display("FAIL reset_hold: got %h want %h", obs(), 34'h0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (obs() !== 34'h0) begin
      bad++;
      $display("FAIL reset_after: got %h want %h", obs(), 34'h0);
    end
  endtask

  task automatic test_start();
    press(1, 0, 0, 2);
    press(1, 0, 0, 3);
    total++;
    if (sw.running !== 1'b0) begin
      bad++;
      $display("FAIL short_press: got %b want 0", sw.running);
    end
    press(1, 0, 0, 5);
    total++;
    if (sw.running !== 1'b1) begin
      bad++;
      $display("FAIL start_run: got %b want 1", sw.running);
    end
    wait_run(1000);
    total++;
    if ({sw.sec, sw.centisec} !== {8'd1, 8'd0}) begin
      bad++;
      $display("FAIL first_sec: got %0d.%0d want 1.0",
               sw.sec, sw.centisec);
    end
    total++;
    if (obs() !== exp_out()) begin
      bad++;
      $display("FAIL start_model: got %h want %h", obs(), exp_out());
    end
  endtask

  task automatic test_pause_clear();
    press(1, 0, 0, 5);
    press(0, 1, 0, 5);
    total++;
    if (obs() !== 34'h0) begin
      bad++;
      $display("FAIL idle_zero: got %h want %h", obs(), 34'h0);
    end
    press(1, 0, 0, 5);
    wait_run(367);
    press(1, 0, 0, int'($urandom_range(4, 7)));
    total++;
    if ({sw.centisec, sw.running} !== {8'd37, 1'b0}) begin
      bad++;
      $display("FAIL pause37: got %0d/%b want 37/0",
               sw.centisec, sw.running);
    end
    repeat ($urandom_range(20, 80)) @(negedge clk);
    total++;
    if (obs() !== exp_out()) begin
      bad++;
      $display("FAIL pause_hold: got %h want %h", obs(), exp_out());
    end
    press(0, 1, 0, 5);
    total++;
    if (obs() !== 34'h0) begin
      bad++;
      $display("FAIL clr_pause: got %h want %h", obs(), 34'h0);
    end
  endtask

  task automatic test_clr_running();
    press(1, 0, 0, 5);
    repeat ($urandom_range(50, 300)) @(negedge clk);
    press(0, 1, 0, int'($urandom_range(4, 7)));
    total++;
    if (sw.running !== 1'b1) begin
      bad++;
      $display("FAIL clr_run: got %b want 1", sw.running);
    end
    repeat ($urandom_range(30, 200)) @(negedge clk);
    total++;
    if (obs() !== exp_out()) begin
      bad++;
      $display("FAIL clr_run_model: got %h want %h", obs(), exp_out());
    end
  endtask

  // preset to xx:59:59.99 just before a tick; t is the tick count
  task automatic preload(input bit full, input longint t);
    for (int i = 0; i < 12 && (m_run % 10) != 9; i++)
      @(negedge clk);
    pre_val = t * 10 + 9;
    pre_at  = cyc + 1;
    force u_dut.cs_q  = 7'd99;
    force u_dut.sec_q = 7'd59;
    force u_dut.min_q = 7'd59;
    if (full) force u_dut.hour_q = 7'd99;
    else      force u_dut.hour_q = 7'd0;
    #1;
    release u_dut.cs_q;
    release u_dut.sec_q;
    release u_dut.min_q;
    release u_dut.hour_q;
    @(negedge clk);
  endtask

  task automatic test_cascade();
    preload(1'b0, 64'd359999);
    total++;
    if (obs() !== {8'd0, 8'd0, 8'd0, 8'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL carry_hour: got %h want 01:00:00.00 run", obs());
    end
    preload(1'b1, 64'd35999999);
    total++;
    if (obs() !== {32'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL wrap99: got %h want 00:00:00.00 run", obs());
    end
    repeat ($urandom_range(30, 120)) @(negedge clk);
    total++;
    if (obs() !== exp_out()) begin
      bad++;
      $display("FAIL after_wrap: got %h want %h", obs(), exp_out());
    end
  endtask

  task automatic test_lap();
    press(1, 0, 0, 5);
    press(0, 1, 0, 5);
    press(1, 0, 0, 5);
    wait_run(5196);
    press(0, 0, 1, int'($urandom_range(4, 7)));
    total++;
    if (obs() !== {8'd20, 8'd5, 8'd0, 8'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL lap_freeze: got %h want 00:00:05.20 hold", obs());
    end
    repeat ($urandom_range(100, 400)) @(negedge clk);
    total++;
    if ({sw.sec, sw.centisec} !== {8'd5, 8'd20}) begin
      bad++;
      $display("FAIL lap_frozen: got %0d.%0d want 5.20",
               sw.sec, sw.centisec);
    end
    press(0, 0, 1, 5);
    total++;
    if (obs() !== exp_out()) begin
      bad++;
      $display("FAIL lap_release: got %h want %h", obs(), exp_out());
    end
    press(0, 0, 1, 5);
    press(1, 0, 0, 5);
    press(0, 0, 1, 5);
    total++;
    if (obs() !== exp_out()) begin
      bad++;
      $display("FAIL lap_pause: got %h want %h", obs(), exp_out());
    end
    press(0, 1, 0, 5);
    total++;
    if (obs() !== 34'h0) begin
      bad++;
      $display("FAIL lap_clr: got %h want %h", obs(), 34'h0);
    end
  endtask

  task automatic test_simul();
    press(1, 0, 0, 5);
    repeat ($urandom_range(20, 200)) @(negedge clk);
    press(1, 0, 1, 5);
    total++;
    if (obs() !== exp_out()) begin
      bad++;
      $display("FAIL ss_lap: got %h want %h", obs(), exp_out());
    end
    press(1, 1, 0, 5);
    total++;
    if (obs() !== 34'h0) begin
      bad++;
      $display("FAIL ss_clr: got %h want %h", obs(), 34'h0);
    end
  endtask

  task automatic test_async_reset();
    press(1, 0, 0, 5);
    repeat ($urandom_range(100, 500)) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs() !== 34'h0) begin
      bad++;
      $display("FAIL async_rst: got %h want %h", obs(), 34'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    press(1, 0, 0, 5);
    total++;
    if (obs() !== {32'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL rst_idle: got %h want run from zero", obs());
    end
  endtask

  task automatic test_random();
    bit s;
    bit c;
    bit l;
    for (int i = 0; i < 12; i++) begin
      {s, c, l} = 3'($urandom_range(1, 7));
      press(s, c, l, int'($urandom_range(2, 7)));
      total++;
      if (obs() !== exp_out()) begin
        bad++;
        $display("FAIL rand_press%0d: got %h want %h",
                 i, obs(), exp_out());
      end
      repeat ($urandom_range(0, 150)) @(negedge clk);
      total++;
      if (obs() !== exp_out()) begin
        bad++;
        $display("FAIL rand_gap%0d: got %h want %h",
                 i, obs(), exp_out());
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sw.btn_ss  = 1'b0;
    sw.btn_clr = 1'b0;
    sw.btn_lap = 1'b0;
    test_reset();
    test_start();
    test_pause_clear();
    test_clr_running();
    test_cascade();
    test_lap();
    test_simul();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
